// File: rtl/pwm_array_v2.sv
// ---------------------------------------------------------------------------
// pwm_array_v2
//
// Multi-channel ultrasound PWM output stage. A free-running period counter
// (TIME) runs from 0 to CYCLE-1 and wraps. Each channel is high for a window
// of D clocks centred on its phase P'. Per-channel duty, phase and enable are
// first captured into shadow registers by UPDATE. They are then committed to
// the active set only at a period boundary (last clock of the period, or a
// SYNC pulse), so a channel never changes shape in the middle of a period.
//
// Ports
//   CLK            system clock
//   RST            asynchronous, active-high reset
//   UPDATE         one-clock pulse, captures DUTY/PHASE/CH_EN into the shadows
//   SYNC           one-clock pulse, restarts the counter at 0 and commits shadows
//   DUTY           per-channel duty in clocks, channel i at [i*(CW+1) +: CW+1]
//   PHASE          per-channel phase in clocks, channel i at [i*CW +: CW]
//   CH_EN          per-channel enable; a disabled channel drives 0 in PWM mode
//   OUTPUT_EN      1: PWM on enabled channels, 0: idle/balance pattern
//   OUTPUT_BALANCE with OUTPUT_EN=0, toggle every output each clock, else 0
//   TIME           current period counter
//   PENDING        shadow data captured but not yet committed
//   PWM_OUT        registered per-channel output, one clock behind TIME
// ---------------------------------------------------------------------------
module pwm_array_v2 #(
    parameter int TRANS_NUM      = 249,
    parameter int CYCLE          = 512,
    parameter     PHASE_INVERTED = "TRUE",
    parameter int CW             = $clog2(CYCLE)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      UPDATE,
    input  logic                      SYNC,
    input  logic [TRANS_NUM*(CW+1)-1:0] DUTY,
    input  logic [TRANS_NUM*CW-1:0]   PHASE,
    input  logic [TRANS_NUM-1:0]      CH_EN,
    input  logic                      OUTPUT_EN,
    input  logic                      OUTPUT_BALANCE,
    output logic [CW-1:0]             TIME,
    output logic                      PENDING,
    output logic [TRANS_NUM-1:0]      PWM_OUT
);

    // The string parameter is widened to a fixed size so that "TRUE" and
    // "FALSE" (different literal widths) compare cleanly.
    localparam logic [63:0] PHASE_MODE = 64'(PHASE_INVERTED);
    localparam bit          INVERT     = (PHASE_MODE == 64'("TRUE"));

    // One extra bit lets CYCLE itself (up to 2^CW) and every modulo
    // intermediate be represented without overflow.
    localparam logic [CW:0]   CYC  = (CW+1)'(CYCLE);
    localparam logic [CW-1:0] LAST = CW'(CYCLE - 1);

    logic [CW-1:0]             r_time;
    logic                      r_pending;
    logic                      r_balance;
    logic [TRANS_NUM*(CW+1)-1:0] r_shadowDuty;
    logic [TRANS_NUM*CW-1:0]   r_shadowPhase;
    logic [TRANS_NUM-1:0]      r_shadowEn;
    logic [TRANS_NUM*(CW+1)-1:0] r_activeDuty;
    logic [TRANS_NUM*CW-1:0]   r_activePhase;
    logic [TRANS_NUM-1:0]      r_activeEn;
    logic [TRANS_NUM-1:0]      r_pwmOut;

    logic                      w_lastClock;
    logic                      w_commit;
    logic [CW:0]               w_timeExt;
    logic [TRANS_NUM-1:0]      w_raw;

    assign w_lastClock = (r_time == LAST);
    // A boundary is either the natural end of the period or a SYNC pulse;
    // nothing is copied unless the shadow actually holds new data.
    assign w_commit    = (w_lastClock || SYNC) && r_pending;
    assign w_timeExt   = {1'b0, r_time};

    // Period counter: wraps at CYCLE-1, SYNC truncates the current period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_time <= '0;
        end else if (SYNC || w_lastClock) begin
            r_time <= '0;
        end else begin
            r_time <= r_time + CW'(1);
        end
    end

    // Shadow capture and commit. The commit reads the shadow value from before
    // this edge, so an UPDATE landing on a boundary clock is held back for the
    // following boundary and PENDING stays set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shadowDuty  <= '0;
            r_shadowPhase <= '0;
            r_shadowEn    <= '0;
            r_activeDuty  <= '0;
            r_activePhase <= '0;
            r_activeEn    <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (w_commit) begin
                r_activeDuty  <= r_shadowDuty;
                r_activePhase <= r_shadowPhase;
                r_activeEn    <= r_shadowEn;
            end
            if (UPDATE) begin
                r_shadowDuty  <= DUTY;
                r_shadowPhase <= PHASE;
                r_shadowEn    <= CH_EN;
                r_pending     <= 1'b1;
            end else if (w_commit) begin
                r_pending     <= 1'b0;
            end
        end
    end

    // Per-channel window decode. The window starts half a duty before the
    // phase point; for odd duty the rounding puts the extra clock at the end.
    for (genvar g = 0; g < TRANS_NUM; g++) begin : g_ch
        logic [CW:0] w_dutyIn;
        logic [CW:0] w_duty;
        logic [CW:0] w_phaseIn;
        logic [CW:0] w_phase;
        logic [CW:0] w_startSum;
        logic [CW:0] w_start;
        logic [CW:0] w_endSum;
        logic [CW:0] w_end;

        assign w_dutyIn   = r_activeDuty[g*(CW+1) +: CW+1];
        assign w_duty     = (w_dutyIn > CYC) ? CYC : w_dutyIn;
        assign w_phaseIn  = {1'b0, r_activePhase[g*CW +: CW]};
        assign w_phase    = (INVERT && (w_phaseIn != '0)) ? (CYC - w_phaseIn) : w_phaseIn;
        assign w_startSum = w_phase + CYC - (w_duty >> 1);
        assign w_start    = (w_startSum >= CYC) ? (w_startSum - CYC) : w_startSum;
        assign w_endSum   = w_start + w_duty;
        assign w_end      = (w_endSum >= CYC) ? (w_endSum - CYC) : w_endSum;

        // start == end only happens for D=0 or D=CYCLE, which are decoded
        // explicitly; otherwise the window is either contiguous or wraps.
        assign w_raw[g] = (w_duty == '0)    ? 1'b0 :
                          (w_duty == CYC)   ? 1'b1 :
                          (w_start < w_end) ? ((w_timeExt >= w_start) && (w_timeExt < w_end)) :
                                              ((w_timeExt >= w_start) || (w_timeExt < w_end));
    end

    // Registered output stage with the idle/balance toggle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_balance <= 1'b0;
            r_pwmOut  <= '0;
        end else begin
            r_balance <= OUTPUT_BALANCE ? ~r_balance : 1'b0;
            if (OUTPUT_EN) begin
                r_pwmOut <= w_raw & r_activeEn;
            end else begin
                r_pwmOut <= {TRANS_NUM{r_balance}};
            end
        end
    end

    assign TIME    = r_time;
    assign PENDING = r_pending;
    assign PWM_OUT = r_pwmOut;

endmodule
